mcontrol_multi: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore FSM that splits each instruction into FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps. This lets one memory and one ALU be shared across steps. It waits on a memory-ready handshake and keeps a retired-instruction counter.

---
 rtl/mips_ctrl_pkg.sv | 81 ++++++++
 rtl/mcontrol_decode.sv | 105 ++++++++++
 rtl/mcontrol_multi.sv | 104 ++++++++++
 tb/tb_mcontrol_multi.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared constants, types and helpers for the multi-cycle MIPS
//               control sequencer: opcodes, FSM state encodings, datapath mux
//               encodings and the control-word structure.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // Supported instruction opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // FSM state encodings; 12..15 are unused and recover to FETCH
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_ADDI_EX = 4'd8;
  localparam logic [3:0] S_ADDI_WB = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  // ALU B-operand select
  localparam logic [1:0] ASB_REGB  = 2'b00;
  localparam logic [1:0] ASB_ONE   = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_BRIMM = 2'b11;

  // ALU operation class; FUNCT hands off to the ALUControl block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Next-PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Full control word driven towards the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  // State entered after DECODE; FETCH means the opcode is not supported
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:     decode_target = S_EXEC;
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_ADDI:      decode_target = S_ADDI_EX;
      OP_BEQ:       decode_target = S_BRANCH;
      OP_J:         decode_target = S_JUMP;
      default:      decode_target = S_FETCH;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcontrol_decode.sv
`default_nettype none
// ============================================================================
// Module      : mcontrol_decode
// Description : Combinational state-to-control-word decoder for the
//               multi-cycle sequencer. Moore decode of state, with the
//               mem_ready-qualified enables and reset gating of every
//               write/request and pulse output.
// Revision    : 1.0 - initial release
// ============================================================================
module mcontrol_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       res,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  ctrl_t c;

  // Per-state control word; anything not set for a state stays 0
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = ASB_ONE;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCS_ALU;
        // IR and PC only capture once the instruction word is really there
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_b = ASB_BRIMM;
        c.alu_op    = ALUOP_ADD;
        c.illegal   = (decode_target(opcode) == S_FETCH);
      end
      S_MEMADR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ASB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = mem_ready;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ASB_REGB;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = ASB_REGB;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCS_JUMP;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase

    // No architectural side effects may escape while reset is held
    if (res) begin
      c.pc_write      = 1'b0;
      c.pc_write_cond = 1'b0;
      c.mem_read      = 1'b0;
      c.mem_write     = 1'b0;
      c.ir_write      = 1'b0;
      c.reg_write     = 1'b0;
      c.illegal       = 1'b0;
      c.instr_done    = 1'b0;
    end
  end

  assign ctrl = c;

endmodule
`default_nettype wire

// File: rtl/mcontrol_multi.sv
`default_nettype none
// ============================================================================
// Module      : mcontrol_multi
// Description : Multi-cycle MIPS control sequencer. Holds the FSM state, the
//               opcode latched in DECODE and the retired-instruction counter;
//               control outputs come from mcontrol_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mcontrol_multi
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                res,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                illegal,
  output logic                instr_done,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state
);

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [5:0] op_q;
  logic [RETIRE_W-1:0] retired_q;
  ctrl_t ctrl;

  mcontrol_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .res       (res),
    .opcode    (opcode),
    .ctrl      (ctrl)
  );

  // Next-state selection; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = decode_target(opcode);
      S_MEMADR:  state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_ALUWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // State, latched opcode and retire counter; reset aborts any wait
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
      if (ctrl.instr_done) begin
        retired_q <= retired_q + RETIRE_ONE;
      end
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign illegal     = ctrl.illegal;
  assign instr_done  = ctrl.instr_done;
  assign retired     = retired_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mcontrol_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcontrol_multi
// Description : Self-checking bench for mcontrol_multi. A per-cycle vector
//               table covers reset, every instruction class, memory waits,
//               an illegal opcode and reset during a store wait; a second
//               4-bit-counter instance checks retire wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcontrol_multi;
  import mips_ctrl_pkg::*;

  logic        clk;
  logic        res;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA, illegal, instr_done;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [31:0] retired;
  logic [3:0]  state;

  logic s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead, s_MemWrite, s_IRWrite;
  logic s_MemtoReg, s_RegDst, s_RegWrite, s_ALUSrcA, s_illegal, s_instr_done;
  logic [1:0] s_ALUSrcB, s_ALUOp, s_PCSource;
  logic [3:0] s_retired;
  logic [3:0] s_state;

  int n_tests;
  int n_fail;

  mcontrol_multi #(.RETIRE_W(32)) dut (
    .clk(clk), .res(res), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal(illegal), .instr_done(instr_done),
    .retired(retired), .state(state)
  );

  mcontrol_multi #(.RETIRE_W(4)) dut4 (
    .clk(clk), .res(res), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IorD(s_IorD),
    .MemRead(s_MemRead), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
    .MemtoReg(s_MemtoReg), .RegDst(s_RegDst), .RegWrite(s_RegWrite),
    .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ALUOp(s_ALUOp),
    .PCSource(s_PCSource), .illegal(s_illegal), .instr_done(s_instr_done),
    .retired(s_retired), .state(s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word, same field order as mk() below
  logic [17:0] act_ctl;
  assign act_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, illegal, instr_done};

  typedef struct {
    logic        res;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];

  function automatic logic [17:0] mk(
    input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
    input logic [1:0] asb, aop, pcs,
    input logic ill, done);
    mk = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, done};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [17:0] ctl,
                     input logic [31:0] ret);
    vec_t v;
    v.res = r; v.op = op; v.mr = mr; v.st = st; v.ctl = ctl; v.ret = ret;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand-computed expected control words
  logic [17:0] c_rst_fetch, c_rst_memwr, c_fetch_w, c_fetch_r, c_decode, c_decode_ill;
  logic [17:0] c_memadr, c_memrd, c_memwb, c_memwr_w, c_memwr_r, c_exec, c_aluwb;
  logic [17:0] c_addi_ex, c_addi_wb, c_branch, c_jump;

  initial begin
    //                  pcw pcwc iord mrd mwr irw m2r rdst rw asa  asb    aop    pcs  ill done
    c_rst_fetch  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    c_rst_memwr  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    c_fetch_w    = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    c_fetch_r    = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    c_decode     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
    c_decode_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
    c_memadr     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    c_memrd      = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    c_memwb      = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    c_memwr_w    = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    c_memwr_r    = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    c_exec       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
    c_aluwb      = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    c_addi_ex    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    c_addi_wb    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    c_branch     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1);
    c_jump       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 1);

    // One record per cycle: inputs applied this cycle, expected state/outputs
    // R-type under reset, then through EXEC/ALUWB
    add(1, 6'b000000, 1, S_FETCH,   c_rst_fetch,  0);
    add(1, 6'b000000, 1, S_FETCH,   c_rst_fetch,  0);
    add(0, 6'b000000, 1, S_FETCH,   c_fetch_r,    0);
    add(0, 6'b000000, 1, S_DECODE,  c_decode,     0);
    add(0, 6'b000000, 1, S_EXEC,    c_exec,       0);
    add(0, 6'b000000, 1, S_ALUWB,   c_aluwb,      0);
    // lw with three wait cycles in MEMRD
    add(0, 6'b100011, 1, S_FETCH,   c_fetch_r,    1);
    add(0, 6'b100011, 1, S_DECODE,  c_decode,     1);
    add(0, 6'b100011, 1, S_MEMADR,  c_memadr,     1);
    add(0, 6'b100011, 0, S_MEMRD,   c_memrd,      1);
    add(0, 6'b100011, 0, S_MEMRD,   c_memrd,      1);
    add(0, 6'b100011, 0, S_MEMRD,   c_memrd,      1);
    add(0, 6'b100011, 1, S_MEMRD,   c_memrd,      1);
    add(0, 6'b100011, 1, S_MEMWB,   c_memwb,      1);
    // sw with two wait cycles in FETCH
    add(0, 6'b101011, 0, S_FETCH,   c_fetch_w,    2);
    add(0, 6'b101011, 0, S_FETCH,   c_fetch_w,    2);
    add(0, 6'b101011, 1, S_FETCH,   c_fetch_r,    2);
    add(0, 6'b101011, 1, S_DECODE,  c_decode,     2);
    add(0, 6'b101011, 1, S_MEMADR,  c_memadr,     2);
    add(0, 6'b101011, 1, S_MEMWR,   c_memwr_r,    2);
    // beq then j
    add(0, 6'b000100, 1, S_FETCH,   c_fetch_r,    3);
    add(0, 6'b000100, 1, S_DECODE,  c_decode,     3);
    add(0, 6'b000100, 1, S_BRANCH,  c_branch,     3);
    add(0, 6'b000010, 1, S_FETCH,   c_fetch_r,    4);
    add(0, 6'b000010, 1, S_DECODE,  c_decode,     4);
    add(0, 6'b000010, 1, S_JUMP,    c_jump,       4);
    // illegal opcode, then addi
    add(0, 6'b111111, 1, S_FETCH,   c_fetch_r,    5);
    add(0, 6'b111111, 1, S_DECODE,  c_decode_ill, 5);
    add(0, 6'b001000, 1, S_FETCH,   c_fetch_r,    5);
    add(0, 6'b001000, 1, S_DECODE,  c_decode,     5);
    add(0, 6'b001000, 1, S_ADDI_EX, c_addi_ex,    5);
    add(0, 6'b001000, 1, S_ADDI_WB, c_addi_wb,    5);
    // sw whose memory wait is aborted by reset
    add(0, 6'b101011, 1, S_FETCH,   c_fetch_r,    6);
    add(0, 6'b101011, 1, S_DECODE,  c_decode,     6);
    add(0, 6'b101011, 0, S_MEMADR,  c_memadr,     6);
    add(0, 6'b101011, 0, S_MEMWR,   c_memwr_w,    6);
    add(1, 6'b101011, 0, S_MEMWR,   c_rst_memwr,  6);
    add(0, 6'b101011, 0, S_FETCH,   c_fetch_w,    0);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    res = 1'b1;
    opcode = 6'd0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      @(negedge clk);
      res       = vq[i].res;
      opcode    = vq[i].op;
      mem_ready = vq[i].mr;
      #1;
      chk($sformatf("v%0d state", i),   {28'd0, state},   {28'd0, vq[i].st});
      chk($sformatf("v%0d ctl", i),     {14'd0, act_ctl}, {14'd0, vq[i].ctl});
      chk($sformatf("v%0d retired", i), retired,          vq[i].ret);
    end

    // Retire wrap: 16 back-to-back R-type instructions, 4 cycles each
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    opcode = 6'b000000;
    mem_ready = 1'b1;
    #1;
    chk("wrap start retired4", {28'd0, s_retired}, 32'd0);
    repeat (60) @(negedge clk);
    #1;
    chk("wrap 15 state",     {28'd0, state},     {28'd0, S_FETCH});
    chk("wrap 15 retired",   retired,            32'd15);
    chk("wrap 15 retired4",  {28'd0, s_retired}, 32'd15);
    repeat (3) @(negedge clk);
    #1;
    chk("wrap last done4",   {31'd0, s_instr_done}, 32'd1);
    @(negedge clk);
    #1;
    chk("wrap 16 retired",   retired,            32'd16);
    chk("wrap 16 retired4",  {28'd0, s_retired}, 32'd0);
    chk("wrap 16 state4",    {28'd0, s_state},   {28'd0, S_FETCH});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
